game_session_ctrl: RTL and testbench
====================================

GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

Interface
REQ-001 SHALL have parameter NUM_HOOPS, default 3, meaning the number of independent hoop make-pulse channels.
REQ-002 SHALL have parameter SCORE_W, default 8, meaning the score counter width.
REQ-003 SHALL have parameter TIME_W, default 8, meaning the time counter width.
REQ-004 SHALL have parameter TICK_DIV, default 50000000, meaning clock cycles per game-time tick (≥2).
REQ-005 SHALL have parameter START_TIME, default 30, meaning the countdown start value in timed mode.
REQ-006 SHALL have parameter END_SCORE, default 10, meaning the target score in race mode.
REQ-007 SHALL have port clock, input, 1, the single clock; reset is synchronous and active-low.
REQ-008 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-009 SHALL have port mode, input, 1: 0 = timed (count down, maximise score), 1 = race (count up to END_SCORE).
REQ-010 SHALL have port start, input, 1, a level sampled every cycle that requests a new game.
REQ-011 SHALL have port hoop_make, input, NUM_HOOPS, one-cycle make pulses, already debounced and synchronised.
REQ-012 SHALL have port score, output, SCORE_W, the current score.
REQ-013 SHALL have port time_disp, output, TIME_W, the remaining time (mode 0) or the elapsed time (mode 1).
REQ-014 SHALL have port running, output, 1, high in state RUN.
REQ-015 SHALL have port game_over, output, 1, high in state DONE.
REQ-016 SHALL have port lb_update, output, 1, a one-cycle leaderboard write strobe.
REQ-017 SHALL have port lb_value, output, max(SCORE_W,TIME_W), holding the final score (mode 0) or the final elapsed time (mode 1), valid while lb_update is high.

Function
REQ-018 SHALL implement the states IDLE, RUN and DONE; start=1 in IDLE or DONE moves to RUN on the next edge, and start is ignored in RUN.
REQ-019 SHALL latch mode into mode_q on the IDLE/DONE->RUN transition, and mode changes during RUN SHALL have no effect.
REQ-020 SHALL, on entering RUN, clear score to 0, the tick counter to 0 and elapsed to 0, and load remaining with START_TIME.
REQ-021 SHALL, in RUN, count the tick counter 0..TICK_DIV-1 and wrap; tick is asserted in the cycle where the counter equals TICK_DIV-1.
REQ-022 SHALL, in RUN, add the popcount of hoop_make to score each cycle, so that simultaneous makes on several channels all count.
REQ-023 SHALL saturate score at 2^SCORE_W-1 in mode 0, and clamp score at END_SCORE in mode 1.
REQ-024 SHALL, in mode 0, decrement remaining on each tick; the tick taking remaining to 0 moves the block to DONE.
REQ-025 SHALL, in mode 1, increment elapsed on each tick, saturating at 2^TIME_W-1; reaching score ≥ END_SCORE moves the block to DONE.
REQ-026 SHALL, when a make and the terminating tick occur in the same cycle, apply both updates before entering DONE.
REQ-027 SHALL drive time_disp = mode_q ? elapsed : remaining, registered.
REQ-028 SHALL, in DONE, hold score and time_disp frozen and ignore hoop_make and tick.
REQ-029 SHALL assert lb_update for exactly one cycle, the first cycle in DONE, and SHALL NOT re-assert it while the block stays in DONE.
REQ-030 SHALL apply a start=1 arriving in the same cycle as the lb_update pulse on the next edge, and the pulse SHALL still be emitted.

Reset
REQ-031 SHALL, with reset=0 at a clock edge, enter IDLE regardless of state (including mid-RUN), with mode_q=0, score=0, elapsed=0, remaining=START_TIME and tick counter=0.
REQ-032 SHALL give the following output reset values: score=0, time_disp=START_TIME, running=0, game_over=0, lb_update=0, lb_value=0.

Configuration
REQ-033 SHALL, with GAME_BONUS_EN defined in mode 0, add 2× popcount per cycle while remaining ≤ 5 (final-seconds bonus).
REQ-034 SHALL, without GAME_BONUS_EN, add 1× popcount in all cases, and mode 1 SHALL be unaffected either way.

Structure
REQ-035 SHALL place the state enum (IDLE/RUN/DONE), the mode constants (MODE_TIMED=0, MODE_RACE=1) and the bonus window constant (5) in the shared package game_pkg.
REQ-036 SHALL contain one sub-module, game_tick_div, holding the TICK_DIV counter with ports clock, reset, clear, enable and tick.

Verification (NUM_HOOPS=3, TICK_DIV=4, START_TIME=5, END_SCORE=3)
REQ-037 SHALL cover: mode 0, start pulse, no makes -> running=1 for 20 cycles, time_disp steps 5,4,3,2,1,0, then game_over=1, a single lb_update with lb_value=0.
REQ-038 SHALL cover: mode 0, hoop_make=3'b111 for one cycle in RUN -> score=3 the next cycle (6 with GAME_BONUS_EN when remaining ≤5).
REQ-039 SHALL cover: mode 1, one make per tick -> DONE when score=3, time_disp=elapsed, lb_value=elapsed, and a later make leaves score at 3.
REQ-040 SHALL cover: mode 0, a make in the same cycle as the final tick -> score includes that make, and lb_value equals the final score.
REQ-041 SHALL cover: reset=0 mid-RUN with score=2 -> next cycle IDLE, score=0, time_disp=5, running=0, no lb_update.
REQ-042 SHALL cover: start held high through DONE -> one lb_update, then a new RUN with score=0 and time_disp=5.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared states, mode codes and bonus window for the game session controller
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } game_state_t;

  localparam logic MODE_TIMED   = 1'b0;
  localparam logic MODE_RACE    = 1'b1;
  localparam int   BONUS_WINDOW = 5;

endpackage

// File: rtl/game_tick_div.sv
// rtl/game_tick_div.sv - game-time tick divider, counts 0..TICK_DIV-1 while enabled
module game_tick_div #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/game_session_ctrl.sv
// rtl/game_session_ctrl.sv - basketball game session FSM: timed/race modes, scoring, leaderboard strobe
// Optional GAME_BONUS_EN: doubles makes in timed mode during the final-seconds window.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int NUM_HOOPS  = 3,
  parameter int SCORE_W    = 8,
  parameter int TIME_W     = 8,
  parameter int TICK_DIV   = 50000000,
  parameter int START_TIME = 30,
  parameter int END_SCORE  = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 start,
  input  logic [NUM_HOOPS-1:0] hoop_make,
  output logic [SCORE_W-1:0]   score,
  output logic [TIME_W-1:0]    time_disp,
  output logic                 running,
  output logic                 game_over,
  output logic                 lb_update,
  output logic [((SCORE_W > TIME_W) ? SCORE_W : TIME_W)-1:0] lb_value
);

  localparam int LB_W  = (SCORE_W > TIME_W) ? SCORE_W : TIME_W;
  localparam int ADD_W = $clog2(2 * NUM_HOOPS + 1);
  localparam int SUM_W = SCORE_W + ADD_W + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [TIME_W-1:0]  TIME_MAX  = '1;

  game_state_t        state_q, state_d;
  logic               mode_q, mode_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TIME_W-1:0]  remaining_q, remaining_d;
  logic [TIME_W-1:0]  elapsed_q, elapsed_d;
  logic [TIME_W-1:0]  time_disp_q, time_disp_d;
  logic               lb_update_q, lb_update_d;
  logic [LB_W-1:0]    lb_value_q, lb_value_d;
  logic [ADD_W-1:0]   pop, add;
  logic [SUM_W-1:0]   sum;
  logic               tick;

  game_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != RUN),
    .enable (state_q == RUN),
    .tick   (tick)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_HOOPS; i++) begin
      pop = pop + ADD_W'(hoop_make[i]);
    end
`ifdef GAME_BONUS_EN
    add = (mode_q == MODE_TIMED && remaining_q <= TIME_W'(BONUS_WINDOW)) ? ADD_W'(pop << 1) : pop;
`else
    add = pop;
`endif
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    score_d     = score_q;
    remaining_d = remaining_q;
    elapsed_d   = elapsed_q;
    lb_update_d = 1'b0;
    lb_value_d  = lb_value_q;
    sum         = SUM_W'(score_q) + SUM_W'(add);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          mode_d      = mode;
          score_d     = '0;
          remaining_d = TIME_W'(START_TIME);
          elapsed_d   = '0;
        end
      end
      RUN: begin
        if (mode_q == MODE_RACE) begin
          score_d = (sum >= SUM_W'(END_SCORE)) ? SCORE_W'(END_SCORE) : SCORE_W'(sum);
        end else begin
          score_d = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(sum);
        end
        if (tick) begin
          if (mode_q == MODE_TIMED) begin
            if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
            if (remaining_q <= TIME_W'(1)) state_d = DONE;
          end else if (elapsed_q != TIME_MAX) begin
            elapsed_d = elapsed_q + 1'b1;
          end
        end
        if (mode_q == MODE_RACE && sum >= SUM_W'(END_SCORE)) state_d = DONE;
        // Strobe is registered, so it lands on the first DONE cycle with the final values.
        if (state_d == DONE) begin
          lb_update_d = 1'b1;
          lb_value_d  = (mode_q == MODE_RACE) ? LB_W'(elapsed_d) : LB_W'(score_d);
        end
      end
      default: state_d = IDLE;
    endcase
    time_disp_d = mode_d ? elapsed_d : remaining_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_TIMED;
      score_q     <= '0;
      remaining_q <= TIME_W'(START_TIME);
      elapsed_q   <= '0;
      time_disp_q <= TIME_W'(START_TIME);
      lb_update_q <= 1'b0;
      lb_value_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      score_q     <= score_d;
      remaining_q <= remaining_d;
      elapsed_q   <= elapsed_d;
      time_disp_q <= time_disp_d;
      lb_update_q <= lb_update_d;
      lb_value_q  <= lb_value_d;
    end
  end

  assign score     = score_q;
  assign time_disp = time_disp_q;
  assign running   = (state_q == RUN);
  assign game_over = (state_q == DONE);
  assign lb_update = lb_update_q;
  assign lb_value  = lb_value_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// tb/tb_game_session_ctrl.sv - randomized scoreboard bench for game_session_ctrl
module tb_game_session_ctrl;

  localparam int NUM_HOOPS  = 3;
  localparam int TICK_DIV   = 4;
  localparam int START_TIME = 5;
  localparam int END_SCORE  = 3;
  localparam int SCORE_MAX  = 255;
  localparam int TIME_MAX   = 255;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 mode;
  logic                 start;
  logic [NUM_HOOPS-1:0] hoop_make;
  logic [7:0]           score;
  logic [7:0]           time_disp;
  logic                 running;
  logic                 game_over;
  logic                 lb_update;
  logic [7:0]           lb_value;

  game_session_ctrl #(
    .NUM_HOOPS(NUM_HOOPS), .SCORE_W(8), .TIME_W(8), .TICK_DIV(TICK_DIV),
    .START_TIME(START_TIME), .END_SCORE(END_SCORE)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .start(start), .hoop_make(hoop_make),
    .score(score), .time_disp(time_disp), .running(running), .game_over(game_over),
    .lb_update(lb_update), .lb_value(lb_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    int score;
    int disp;
    bit run;
    bit over;
    bit lbu;
    bit chk_lbv;
    int lbv;
  } exp_t;

  exp_t exp_q[$];
  int   lb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Game-level reference: phase, ticks elapsed since start, cycles spent running.
  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;
  int m_phase, m_mode, m_score, m_ticks, m_cyc;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit m, input logic [2:0] h);
    exp_t e;
    bit   tick_now;
    bit   fin;
    int   add;
    reset = r; start = s; mode = m; hoop_make = h;
    e.chk_lbv = 1'b0; e.lbv = 0; e.lbu = 1'b0;
    if (!r) begin
      m_phase = P_IDLE; m_mode = 0; m_score = 0; m_ticks = 0; m_cyc = 0;
      e.chk_lbv = 1'b1;
    end else if (m_phase != P_RUN) begin
      if (s) begin
        m_phase = P_RUN; m_mode = m; m_score = 0; m_ticks = 0; m_cyc = 0;
      end
    end else begin
      tick_now = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      m_cyc++;
      add = $countones(h);
`ifdef GAME_BONUS_EN
      if (m_mode == 0 && (START_TIME - m_ticks) <= 5) add = add * 2;
`endif
      m_score = m_mode ? min_i(m_score + add, END_SCORE) : min_i(m_score + add, SCORE_MAX);
      if (tick_now) m_ticks++;
      fin = m_mode ? (m_score >= END_SCORE) : (m_ticks == START_TIME);
      if (fin) begin
        m_phase = P_DONE;
        e.lbu = 1'b1; e.chk_lbv = 1'b1;
        e.lbv = m_mode ? min_i(m_ticks, TIME_MAX) : m_score;
        lb_q.push_back(e.lbv);
      end
    end
    e.score = m_score;
    e.disp  = m_mode ? min_i(m_ticks, TIME_MAX) : START_TIME - m_ticks;
    e.run   = (m_phase == P_RUN);
    e.over  = (m_phase == P_DONE);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input bit s, input bit m);
    for (int i = 0; i < n; i++) drive(1'b1, s, m, 3'b000);
  endtask

  initial begin : monitor
    exp_t e;
    int   lv;
    @(posedge clock);
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("score", int'(score), e.score);
        check("time_disp", int'(time_disp), e.disp);
        check("running", int'(running), int'(e.run));
        check("game_over", int'(game_over), int'(e.over));
        check("lb_update", int'(lb_update), int'(e.lbu));
        if (e.chk_lbv && !e.lbu) check("lb_value_reset", int'(lb_value), e.lbv);
        if (lb_update) begin
          if (lb_q.size() == 0) begin
            check("lb_unexpected", 1, 0);
          end else begin
            lv = lb_q.pop_front();
            check("lb_value", int'(lb_value), lv);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit r, s, m;
    logic [2:0] h;
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    idle(2, 1'b0, 1'b0);
    // Timed game, no makes.
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    idle(24, 1'b0, 1'b1);
    // Timed game, three simultaneous makes.
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    idle(2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 3'b111);
    idle(20, 1'b0, 1'b0);
    // Race game, one make per tick period, then makes after DONE.
    drive(1'b1, 1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b0, (i % 4 == 0) ? 3'b001 : 3'b000);
    drive(1'b1, 1'b0, 1'b0, 3'b101);
    idle(3, 1'b0, 1'b0);
    // Timed game, make on the terminating tick.
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    idle(19, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'b011);
    idle(3, 1'b0, 1'b0);
    // Reset mid-run with score 2.
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    idle(2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'b110);
    idle(3, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    idle(3, 1'b0, 1'b0);
    // Start held high through DONE restarts immediately.
    idle(30, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 24) == 0);
      m = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      drive(r, s, m, h);
    end
    idle(2, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("lb_pending", lb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
